// File: rtl/sweep_pkg.sv
// Shared state encoding and width helpers for the partition sweep checker.
// Widths are functions because they depend on the instantiating module's parameters.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sweep_state_e;

    // Widths are sized for the worst case (every vector wrong in every bit), so nothing wraps.
    function automatic int errW(input int numIn);
        return numIn + 1;
    endfunction

    function automatic int mhdW(input int numOut);
        return $clog2(numOut + 1);
    endfunction

    function automatic int hdW(input int numIn, input int numOut);
        return numIn + $clog2(numOut + 1);
    endfunction

endpackage

// File: rtl/sweep_popcount.sv
// Combinational population count of one partition-output difference vector.
module sweep_popcount
    import sweep_pkg::*;
#(
    parameter int NUM_OUT = 4
) (
    input  logic [NUM_OUT-1:0]          vec_i,
    output logic [mhdW(NUM_OUT)-1:0]    count_o
);

    localparam int MHD_W = mhdW(NUM_OUT);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            count_o = count_o + MHD_W'(vec_i[i]);
        end
    end

endmodule

// File: rtl/partition_sweep_checker.sv
// Drives every input vector into the exact and approximate partitions and accumulates
// error count, Hamming-distance sum and worst-case Hamming distance of their responses.
module partition_sweep_checker
    import sweep_pkg::*;
#(
    parameter int NUM_IN  = 7,
    parameter int NUM_OUT = 4,
    parameter int DUT_LAT = 0
) (
    input  logic                               clk_i,
    input  logic                               rst_n_i,
    input  logic                               start_i,
    output logic [NUM_IN-1:0]                  stim_o,
    output logic                               stim_valid_o,
    input  logic [NUM_OUT-1:0]                 exact_po_i,
    input  logic [NUM_OUT-1:0]                 approx_po_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic [errW(NUM_IN)-1:0]            err_count_o,
    output logic [hdW(NUM_IN, NUM_OUT)-1:0]    hd_sum_o,
    output logic [mhdW(NUM_OUT)-1:0]           max_hd_o
);

    localparam int ERR_W = errW(NUM_IN);
    localparam int HD_W  = hdW(NUM_IN, NUM_OUT);
    localparam int MHD_W = mhdW(NUM_OUT);
    localparam int DRN_W = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;
    localparam logic [NUM_IN-1:0] LAST_VEC = {NUM_IN{1'b1}};

    sweep_state_e       state_q, state_d;
    logic [NUM_IN-1:0]  stim_q, stim_d;
    logic               stimValid_q, stimValid_d;
    logic [DRN_W-1:0]   drainCnt_q, drainCnt_d;
    logic               done_q, done_d;
    logic [ERR_W-1:0]   errCount_q, errCount_d;
    logic [HD_W-1:0]    hdSum_q, hdSum_d;
    logic [MHD_W-1:0]   maxHd_q, maxHd_d;
    logic [MHD_W-1:0]   vecHd;
    logic               cmpEn;

    sweep_popcount #(.NUM_OUT(NUM_OUT)) u_popcount (
        .vec_i   (exact_po_i ^ approx_po_i),
        .count_o (vecHd)
    );

    // cmp_en is stim_valid delayed to the cycle the partition's response for that vector is valid.
    if (DUT_LAT == 0) begin : g_noLat
        assign cmpEn = stimValid_q;
    end else begin : g_lat
        logic [DUT_LAT-1:0] validPipe_q;
        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                validPipe_q <= '0;
            end else begin
                validPipe_q[0] <= stimValid_q;
                for (int i = 1; i < DUT_LAT; i++) begin
                    validPipe_q[i] <= validPipe_q[i-1];
                end
            end
        end
        assign cmpEn = validPipe_q[DUT_LAT-1];
    end

    always_comb begin
        state_d     = state_q;
        stim_d      = stim_q;
        stimValid_d = stimValid_q;
        drainCnt_d  = drainCnt_q;
        errCount_d  = errCount_q;
        hdSum_d     = hdSum_q;
        maxHd_d     = maxHd_q;

        if (cmpEn) begin
            if (vecHd != '0) begin
                errCount_d = errCount_q + ERR_W'(1);
            end
            hdSum_d = hdSum_q + HD_W'(vecHd);
            if (vecHd > maxHd_q) begin
                maxHd_d = vecHd;
            end
        end

        unique case (state_q)
            IDLE, DONE: begin
                // A fresh sweep always starts from zeroed metrics, including a restart from DONE.
                if (start_i) begin
                    state_d     = SWEEP;
                    stim_d      = '0;
                    stimValid_d = 1'b1;
                    errCount_d  = '0;
                    hdSum_d     = '0;
                    maxHd_d     = '0;
                end
            end
            SWEEP: begin
                if (stim_q == LAST_VEC) begin
                    stimValid_d = 1'b0;
                    drainCnt_d  = '0;
                    state_d     = (DUT_LAT == 0) ? DONE : DRAIN;
                end else begin
                    stim_d = stim_q + NUM_IN'(1);
                end
            end
            DRAIN: begin
                if (drainCnt_q == DRN_W'(DUT_LAT - 1)) begin
                    state_d = DONE;
                end else begin
                    drainCnt_d = drainCnt_q + DRN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            stim_q      <= '0;
            stimValid_q <= 1'b0;
            drainCnt_q  <= '0;
            done_q      <= 1'b0;
            errCount_q  <= '0;
            hdSum_q     <= '0;
            maxHd_q     <= '0;
        end else begin
            state_q     <= state_d;
            stim_q      <= stim_d;
            stimValid_q <= stimValid_d;
            drainCnt_q  <= drainCnt_d;
            done_q      <= done_d;
            errCount_q  <= errCount_d;
            hdSum_q     <= hdSum_d;
            maxHd_q     <= maxHd_d;
        end
    end

    assign stim_o       = stim_q;
    assign stim_valid_o = stimValid_q;
    assign busy_o       = (state_q == SWEEP) || (state_q == DRAIN);
    assign done_o       = done_q;
    assign err_count_o  = errCount_q;
    assign hd_sum_o     = hdSum_q;
    assign max_hd_o     = maxHd_q;

endmodule

// File: tb/tb_partition_sweep_checker.sv
// Self-checking bench: a combinational (DUT_LAT=0) and a two-stage pipelined (DUT_LAT=2)
// instance are swept with directed and random difference masks and compared to a mask-table model.
module tb_partition_sweep_checker;

    localparam int NUM_IN  = 7;
    localparam int NUM_OUT = 4;
    localparam int NVEC    = 1 << NUM_IN;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstN0, rstN2, start0, start2;
    logic [NUM_IN-1:0]  stim0, stim2;
    logic               valid0, valid2, busy0, busy2, done0, done2;
    logic [NUM_OUT-1:0] exact0, approx0, exact2, approx2;
    logic [7:0]         err0, err2;
    logic [9:0]         hd0, hd2;
    logic [2:0]         max0, max2;

    // Per-vector xor between the exact and approximate partition responses.
    logic [NUM_OUT-1:0] maskTable [NVEC];

    int testsRun    = 0;
    int testsFailed = 0;

    // Combinational partition pair for the zero-latency instance.
    assign exact0  = stim0[3:0];
    assign approx0 = stim0[3:0] ^ maskTable[stim0];

    // Partition pair with two register stages for the DUT_LAT=2 instance.
    logic [NUM_OUT-1:0] ex2a, ex2b, ap2a, ap2b;
    always_ff @(posedge clk) begin
        ex2a <= stim2[3:0];
        ex2b <= ex2a;
        ap2a <= stim2[3:0] ^ maskTable[stim2];
        ap2b <= ap2a;
    end
    assign exact2  = ex2b;
    assign approx2 = ap2b;

    partition_sweep_checker #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .DUT_LAT(0)) u_dut0 (
        .clk_i(clk), .rst_n_i(rstN0), .start_i(start0),
        .stim_o(stim0), .stim_valid_o(valid0),
        .exact_po_i(exact0), .approx_po_i(approx0),
        .busy_o(busy0), .done_o(done0),
        .err_count_o(err0), .hd_sum_o(hd0), .max_hd_o(max0)
    );

    partition_sweep_checker #(.NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .DUT_LAT(2)) u_dut2 (
        .clk_i(clk), .rst_n_i(rstN2), .start_i(start2),
        .stim_o(stim2), .stim_valid_o(valid2),
        .exact_po_i(exact2), .approx_po_i(approx2),
        .busy_o(busy2), .done_o(done2),
        .err_count_o(err2), .hd_sum_o(hd2), .max_hd_o(max2)
    );

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int obsStim(input int sel);  return (sel == 0) ? int'(stim0)  : int'(stim2);  endfunction
    function automatic int obsValid(input int sel); return (sel == 0) ? int'(valid0) : int'(valid2); endfunction
    function automatic int obsBusy(input int sel);  return (sel == 0) ? int'(busy0)  : int'(busy2);  endfunction
    function automatic int obsDone(input int sel);  return (sel == 0) ? int'(done0)  : int'(done2);  endfunction
    function automatic int obsErr(input int sel);   return (sel == 0) ? int'(err0)   : int'(err2);   endfunction
    function automatic int obsHd(input int sel);    return (sel == 0) ? int'(hd0)    : int'(hd2);    endfunction
    function automatic int obsMax(input int sel);   return (sel == 0) ? int'(max0)   : int'(max2);   endfunction

    task automatic setStart(input int sel, input logic val);
        if (sel == 0) start0 = val;
        else          start2 = val;
    endtask

    // Reference metrics straight from the mask table: a vector is wrong when its mask is nonzero.
    task automatic computeModel(output int expErr, output int expHd, output int expMax);
        int d;
        expErr = 0; expHd = 0; expMax = 0;
        for (int v = 0; v < NVEC; v++) begin
            d = $countones(maskTable[v]);
            if (d != 0) expErr++;
            expHd += d;
            if (d > expMax) expMax = d;
        end
    endtask

    task automatic checkIdleState(input int sel, input string tag);
        checkOutput({tag, ".stim"},  obsStim(sel),  0);
        checkOutput({tag, ".valid"}, obsValid(sel), 0);
        checkOutput({tag, ".busy"},  obsBusy(sel),  0);
        checkOutput({tag, ".done"},  obsDone(sel),  0);
        checkOutput({tag, ".err"},   obsErr(sel),   0);
        checkOutput({tag, ".hd"},    obsHd(sel),    0);
        checkOutput({tag, ".max"},   obsMax(sel),   0);
    endtask

    // Starts a sweep, checks the vector order and latency, then the final metrics.
    task automatic applyStimulus(input int sel, input int lat, input bit holdStart, input string tag);
        int cycles, expIdx, eErr, eHd, eMax;
        computeModel(eErr, eHd, eMax);
        @(negedge clk);
        setStart(sel, 1'b1);
        @(negedge clk);
        cycles = 1;
        if (!holdStart) setStart(sel, 1'b0);
        checkOutput({tag, ".clearErr"},  obsErr(sel),  0);
        checkOutput({tag, ".clearHd"},   obsHd(sel),   0);
        checkOutput({tag, ".clearMax"},  obsMax(sel),  0);
        checkOutput({tag, ".busyStart"}, obsBusy(sel), 1);
        expIdx = 0;
        while (!obsDone(sel) && cycles < 1000) begin
            if (obsValid(sel) != 0) begin
                if (obsStim(sel) != expIdx) checkOutput({tag, ".stimOrder"}, obsStim(sel), expIdx);
                expIdx++;
            end
            @(negedge clk);
            cycles++;
        end
        setStart(sel, 1'b0);
        checkOutput({tag, ".doneSeen"},    obsDone(sel), 1);
        checkOutput({tag, ".vectorCount"}, expIdx, NVEC);
        checkOutput({tag, ".latency"},     cycles, NVEC + lat + 1);
        checkOutput({tag, ".err"},         obsErr(sel), eErr);
        checkOutput({tag, ".hd"},          obsHd(sel),  eHd);
        checkOutput({tag, ".max"},         obsMax(sel), eMax);
        checkOutput({tag, ".stimHold"},    obsStim(sel), NVEC - 1);
        checkOutput({tag, ".validAfter"},  obsValid(sel), 0);
        checkOutput({tag, ".busyAfter"},   obsBusy(sel), 0);
        // done and metrics must stay put while nothing restarts the sweep.
        repeat (3) @(negedge clk);
        checkOutput({tag, ".doneStable"},  obsDone(sel), 1);
        checkOutput({tag, ".errStable"},   obsErr(sel), eErr);
    endtask

    task automatic clearMasks();
        for (int v = 0; v < NVEC; v++) maskTable[v] = '0;
    endtask

    initial begin
        int waitCycles;
        rstN0 = 1'b0; rstN2 = 1'b0; start0 = 1'b0; start2 = 1'b0;
        clearMasks();
        repeat (3) @(negedge clk);
        checkIdleState(0, "reset0");
        checkIdleState(1, "reset2");
        rstN0 = 1'b1; rstN2 = 1'b1;
        @(negedge clk);

        $display("[TB] identical partitions");
        applyStimulus(0, 0, 1'b0, "equal");

        $display("[TB] lsb flipped on every vector");
        for (int v = 0; v < NVEC; v++) maskTable[v] = 4'b0001;
        applyStimulus(0, 0, 1'b0, "allLsb");

        $display("[TB] only the last vector differs");
        clearMasks();
        maskTable[NVEC-1] = 4'b1111;
        applyStimulus(0, 0, 1'b0, "lastVec");

        $display("[TB] pipelined partition, first vector differs");
        clearMasks();
        maskTable[0] = 4'b0011;
        applyStimulus(1, 2, 1'b0, "firstVecLat2");

        $display("[TB] reset in the middle of a sweep");
        clearMasks();
        for (int v = 0; v < 40; v++) maskTable[v] = 4'b0110;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        waitCycles = 0;
        while (stim0 != 7'd50 && waitCycles < 500) begin
            @(negedge clk);
            waitCycles++;
        end
        checkOutput("abort.reach50", int'(stim0), 50);
        rstN0 = 1'b0;
        #1;
        checkIdleState(0, "abort");
        @(negedge clk);
        rstN0 = 1'b1;
        @(negedge clk);
        checkIdleState(0, "abortIdle");
        clearMasks();
        applyStimulus(0, 0, 1'b0, "afterAbort");

        $display("[TB] random masks, start held through the sweep, then restart from done");
        for (int v = 0; v < NVEC; v++) maskTable[v] = NUM_OUT'($urandom_range(0, 15));
        applyStimulus(0, 0, 1'b1, "randHold");
        applyStimulus(0, 0, 1'b0, "randRepeat");

        $display("[TB] sparse random masks on both instances");
        for (int v = 0; v < NVEC; v++)
            maskTable[v] = ($urandom_range(0, 3) == 0) ? NUM_OUT'($urandom_range(1, 15)) : '0;
        applyStimulus(0, 0, 1'b0, "sparse0");
        applyStimulus(1, 2, 1'b0, "sparse2");
        applyStimulus(1, 2, 1'b0, "sparse2Repeat");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
